// File: rtl/snn_timestep_scheduler_if.sv
// rtl/snn_timestep_scheduler_if.sv - handshake/bus bundle for snn_timestep_scheduler (SNN_SCHED_SPKCNT_EN adds spk_count)
interface snn_timestep_scheduler_if #(
    parameter int PRE_SYN_LAYER_SIZE = 32,
    parameter int LAYER_SIZE         = 16,
    parameter int TIME_STEPS         = 6,
    parameter int STEP_W             = $clog2(TIME_STEPS + 1)
);
    // frame control
    logic                          start;
    logic                          busy;
    logic                          done;
    logic                          err_timeout;

    // input spike stream
    logic                          in_valid;
    logic                          in_ready;
    logic [PRE_SYN_LAYER_SIZE-1:0] in_spk;

    // layer wrapper side
    logic                          layer_avail;
    logic                          pre_synp_avail;
    logic [PRE_SYN_LAYER_SIZE-1:0] pre_synpt_spk_train;
    logic [LAYER_SIZE-1:0]         post_syn_spk;

    // output spike stream
    logic                          out_valid;
    logic                          out_ready;
    logic [LAYER_SIZE-1:0]         out_spk;
    logic [STEP_W-1:0]             out_step;

`ifdef SNN_SCHED_SPKCNT_EN
    logic [LAYER_SIZE*STEP_W-1:0]  spk_count;
`endif

    // spike source, layer wrapper and sink together
    modport master (
        output start, in_valid, in_spk, layer_avail, post_syn_spk, out_ready,
        input  busy, done, err_timeout, in_ready, pre_synp_avail,
               pre_synpt_spk_train, out_valid, out_spk, out_step
`ifdef SNN_SCHED_SPKCNT_EN
        , input spk_count
`endif
    );

    // the scheduler itself
    modport slave (
        input  start, in_valid, in_spk, layer_avail, post_syn_spk, out_ready,
        output busy, done, err_timeout, in_ready, pre_synp_avail,
               pre_synpt_spk_train, out_valid, out_spk, out_step
`ifdef SNN_SCHED_SPKCNT_EN
        , output spk_count
`endif
    );
endinterface

// File: rtl/snn_timestep_scheduler.sv
// rtl/snn_timestep_scheduler.sv - sequences one SNN layer through a TIME_STEPS frame (SNN_SCHED_SPKCNT_EN adds per-neuron spike counters)
module snn_timestep_scheduler #(
    parameter int PRE_SYN_LAYER_SIZE = 32,
    parameter int LAYER_SIZE         = 16,
    parameter int TIME_STEPS         = 6,
    parameter int FIFO_DEPTH         = 4,
    parameter int ACK_TIMEOUT        = 64,
    parameter int STEP_W             = $clog2(TIME_STEPS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    snn_timestep_scheduler_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(TIME_STEPS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // input spike FIFO
    logic [PRE_SYN_LAYER_SIZE-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]              rd_ptr;
    logic [PTR_W-1:0]              wr_ptr;
    logic [CNT_W-1:0]              count;
    logic [CNT_W-1:0]              count_next;
    logic                          in_ready_q;
    logic                          push;
    logic                          pop;
    logic                          fifo_empty;

    // sequencing state
    logic [STEP_W-1:0]             step_cnt;
    logic [STEP_W-1:0]             step_next;
    logic [TMR_W-1:0]              timer;
    logic [TMR_W-1:0]              timer_next;
    logic                          frame_start;
    logic                          capture;
    logic                          accept;
    logic                          timeout_hit;

    // registered outputs
    logic                          issue_q;
    logic [PRE_SYN_LAYER_SIZE-1:0] train_q;
    logic                          out_valid_q;
    logic [LAYER_SIZE-1:0]         out_spk_q;
    logic [STEP_W-1:0]             out_step_q;
    logic                          busy_q;
    logic                          done_q;
    logic                          err_q;

    assign fifo_empty = (count == '0);
    assign push       = bus.in_valid && in_ready_q;

    // occupancy after this cycle's push/pop; a simultaneous pair leaves it unchanged
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // FIFO pointers, occupancy and the registered not-full flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_next;
            in_ready_q <= (count_next != FULL_CNT);
        end
    end

    // FIFO storage; contents are meaningless until pushed so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.in_spk;
        end
    end

    // next-state and strobe decode for the frame sequencer
    always_comb begin
        state_next  = state;
        step_next   = step_cnt;
        timer_next  = timer;
        pop         = 1'b0;
        frame_start = 1'b0;
        capture     = 1'b0;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    frame_start = 1'b1;
                    step_next   = '0;
                    state_next  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // the layer only gets a vector once it is idle and data is queued
                if (bus.layer_avail && !fifo_empty) begin
                    pop        = 1'b1;
                    timer_next = '0;
                    state_next = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!bus.layer_avail) begin
                    state_next = S_WAIT_DONE;
                end else if (timer == TMR_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = S_DONE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (bus.layer_avail) begin
                    capture    = 1'b1;
                    state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                // out_valid is high throughout EMIT, so out_ready alone completes the handshake
                if (bus.out_ready) begin
                    accept = 1'b1;
                    if (step_cnt == LAST_STEP) begin
                        state_next = S_DONE;
                    end else begin
                        step_next  = step_cnt + 1'b1;
                        state_next = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            step_cnt <= '0;
            timer    <= '0;
        end else begin
            state    <= state_next;
            step_cnt <= step_next;
            timer    <= timer_next;
        end
    end

    // registered outputs toward the layer, the sink and the frame status
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_q     <= 1'b0;
            train_q     <= '0;
            out_valid_q <= 1'b0;
            out_spk_q   <= '0;
            out_step_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            issue_q <= pop;
            if (pop) begin
                train_q <= fifo_mem[rd_ptr];
            end
            if (capture) begin
                out_valid_q <= 1'b1;
                out_spk_q   <= bus.post_syn_spk;
                out_step_q  <= step_cnt;
            end else if (accept) begin
                out_valid_q <= 1'b0;
            end
            busy_q <= (state_next != S_IDLE);
            done_q <= (state_next == S_DONE);
            // only rst clears the timeout flag; a new start leaves it set
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready            = in_ready_q;
    assign bus.pre_synp_avail      = issue_q;
    assign bus.pre_synpt_spk_train = train_q;
    assign bus.out_valid           = out_valid_q;
    assign bus.out_spk             = out_spk_q;
    assign bus.out_step            = out_step_q;
    assign bus.busy                = busy_q;
    assign bus.done                = done_q;
    assign bus.err_timeout         = err_q;

`ifdef SNN_SCHED_SPKCNT_EN
    localparam logic [STEP_W-1:0] SPK_MAX = '1;

    logic [LAYER_SIZE*STEP_W-1:0] spk_cnt_q;

    // saturating per-neuron spike totals, cleared on start and held after done
    always_ff @(posedge clk) begin
        if (rst) begin
            spk_cnt_q <= '0;
        end else if (frame_start) begin
            spk_cnt_q <= '0;
        end else if (accept) begin
            for (int n = 0; n < LAYER_SIZE; n++) begin
                if (out_spk_q[n] && (spk_cnt_q[n*STEP_W +: STEP_W] != SPK_MAX)) begin
                    spk_cnt_q[n*STEP_W +: STEP_W] <= spk_cnt_q[n*STEP_W +: STEP_W] + 1'b1;
                end
            end
        end
    end

    assign bus.spk_count = spk_cnt_q;
`endif

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// tb/tb_snn_timestep_scheduler.sv - self-checking bench for snn_timestep_scheduler
`timescale 1ns/1ps
module tb_snn_timestep_scheduler;
    localparam int PRE = 32;
    localparam int LSZ = 16;
    localparam int TS  = 6;
    localparam int FD  = 4;
    localparam int ACK = 64;
    localparam int SW  = $clog2(TS + 1);

    typedef struct {
        logic [PRE-1:0] vec;
        logic [LSZ-1:0] exp_spk;
        logic [SW-1:0]  exp_step;
    } vec_t;

    typedef struct {
        logic [LSZ-1:0] spk;
        logic [SW-1:0]  step;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snn_timestep_scheduler_if #(
        .PRE_SYN_LAYER_SIZE(PRE), .LAYER_SIZE(LSZ), .TIME_STEPS(TS), .STEP_W(SW)
    ) bus ();

    snn_timestep_scheduler #(
        .PRE_SYN_LAYER_SIZE(PRE), .LAYER_SIZE(LSZ), .TIME_STEPS(TS),
        .FIFO_DEPTH(FD), .ACK_TIMEOUT(ACK), .STEP_W(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit finished = 0;

    // reference model state: vectors in push order, outputs they must produce
    logic [PRE-1:0] exp_issue_q[$];
    out_t           exp_out_q[$];
    logic [PRE-1:0] obs_train_q[$];
    out_t           obs_out_q[$];
    int frame_idx = 0;
    int pulse_cnt = 0;
    int done_cnt = 0;
    int accept_cnt = 0;
    int last_accept_cyc = -1;
    int last_done_cyc = -2;

    // layer model controls
    bit layer_stuck = 0;
    int hold_min = 3;
    int hold_max = 3;
    int lcnt = 0;
    logic [PRE-1:0] lvec;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LSZ-1:0] layer_fn(input logic [PRE-1:0] v);
        return v[15:0] ^ v[31:16] ^ 16'hA5A5;
    endfunction

    task automatic check_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic check_true(input string nm, input bit cond);
        checks++;
        if (!cond) begin
            failures++;
            $display("FAIL %s actual=0 expected=1 at cycle %0d", nm, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [PRE-1:0] v);
        bit rdy;
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_spk   = v;
        do begin
            rdy = bus.in_ready;
            tick();
            n++;
        end while (!rdy && n < 400);
        bus.in_valid = 1'b0;
        check_true("push_accepted", rdy);
        if (rdy) exp_issue_q.push_back(v);
    endtask

    task automatic start_frame();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check_true(nm, done_cnt != d0);
    endtask

    // layer wrapper model: drops avail right after a pulse, raises it with a result later
    initial begin
        bus.layer_avail  = 1'b1;
        bus.post_syn_spk = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                bus.layer_avail = 1'b1;
                lcnt = 0;
            end else if (lcnt > 0) begin
                lcnt--;
                if (lcnt == 0) begin
                    bus.post_syn_spk = layer_fn(lvec);
                    bus.layer_avail  = 1'b1;
                end
            end else if (bus.pre_synp_avail && !layer_stuck) begin
                lvec = bus.pre_synpt_spk_train;
                bus.layer_avail = 1'b0;
                lcnt = $urandom_range(hold_max, hold_min);
            end
        end
    end

    // scoreboard: issue order, step numbering, one-cycle pulses, handshake results
    initial begin
        logic prev_pulse;
        logic prev_avail;
        logic [PRE-1:0] v;
        out_t o;
        out_t e;
        prev_pulse = 1'b0;
        prev_avail = 1'b1;
        forever begin
            @(posedge clk);
            #3;
            if (!rst) begin
                if (bus.start && !bus.busy) frame_idx = 0;
                if (bus.pre_synp_avail) begin
                    pulse_cnt++;
                    check_true("pulse_one_cycle", !prev_pulse);
                    check_true("issue_while_layer_busy", prev_avail);
                    obs_train_q.push_back(bus.pre_synpt_spk_train);
                    check_true("issue_expected", exp_issue_q.size() != 0);
                    if (exp_issue_q.size() != 0) begin
                        v = exp_issue_q.pop_front();
                        check_eq("issue_vec", bus.pre_synpt_spk_train, v);
                        e.spk  = layer_fn(v);
                        e.step = SW'(frame_idx);
                        exp_out_q.push_back(e);
                    end
                    frame_idx++;
                end
                if (bus.out_valid && bus.out_ready) begin
                    accept_cnt++;
                    last_accept_cyc = cyc + 1;
                    o.spk  = bus.out_spk;
                    o.step = bus.out_step;
                    obs_out_q.push_back(o);
                    check_true("out_expected", exp_out_q.size() != 0);
                    if (exp_out_q.size() != 0) begin
                        e = exp_out_q.pop_front();
                        check_eq("out_spk", bus.out_spk, e.spk);
                        check_eq("out_step", bus.out_step, e.step);
                    end
                end
                if (bus.done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                end
            end
            prev_pulse = bus.pre_synp_avail;
            prev_avail = bus.layer_avail;
        end
    end

    initial begin
        vec_t tbl[TS];
        logic [LSZ-1:0] sp;
        logic [SW-1:0]  st;
        int pc0;
        int d0;
        int n;
        int c0;
        bit rnd_run;

        tbl[0] = '{32'h0000_0001, 16'hA5A4, 3'd0};
        tbl[1] = '{32'h0000_0002, 16'hA5A7, 3'd1};
        tbl[2] = '{32'h0000_0004, 16'hA5A1, 3'd2};
        tbl[3] = '{32'h0000_0008, 16'hA5AD, 3'd3};
        tbl[4] = '{32'h0000_0010, 16'hA5B5, 3'd4};
        tbl[5] = '{32'h0000_0020, 16'hA585, 3'd5};

        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_spk    = '0;
        bus.out_ready = 1'b1;

        // reset state
        rst = 1'b1;
        repeat (3) tick();
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_in_ready", bus.in_ready, 0);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_pulse", bus.pre_synp_avail, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_err", bus.err_timeout, 0);
        rst = 1'b0;
        tick();
        tick();
        check_eq("in_ready_after_rst", bus.in_ready, 1);

        // frame 1: table of one-hot vectors, fixed 3-cycle layer
        obs_train_q.delete();
        obs_out_q.delete();
        fork
            begin
                for (int i = 0; i < TS; i++) push_vec(tbl[i].vec);
            end
            begin
                repeat (6) tick();
                start_frame();
                wait_done("t1_done", 600);
            end
        join
        check_eq("t1_issue_count", obs_train_q.size(), TS);
        check_eq("t1_out_count", obs_out_q.size(), TS);
        for (int i = 0; i < TS; i++) begin
            if (i < obs_train_q.size()) check_eq("t1_train", obs_train_q[i], tbl[i].vec);
            if (i < obs_out_q.size()) begin
                check_eq("t1_out_spk", obs_out_q[i].spk, tbl[i].exp_spk);
                check_eq("t1_out_step", obs_out_q[i].step, tbl[i].exp_step);
            end
        end
        check_eq("t1_done_after_last_accept", last_done_cyc, last_accept_cyc);
        tick();
        check_eq("t1_busy_after", bus.busy, 0);
`ifdef SNN_SCHED_SPKCNT_EN
        for (int nn = 0; nn < LSZ; nn++) begin
            int ec;
            ec = 0;
            for (int i = 0; i < TS; i++) ec += tbl[i].exp_spk[nn];
            check_eq("t1_spk_count", bus.spk_count[nn*SW +: SW], ec);
        end
`endif

        // frame 2: start on an empty FIFO, first vector arrives late
        start_frame();
        pc0 = pulse_cnt;
        repeat (10) tick();
        check_eq("t2_no_pulse_empty", pulse_cnt, pc0);
        check_eq("t2_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_spk   = 32'hDEAD_0001;
        tick();
        bus.in_valid = 1'b0;
        exp_issue_q.push_back(32'hDEAD_0001);
        check_eq("t2_no_bypass", bus.pre_synp_avail, 0);
        tick();
        check_eq("t2_issue_after_push", bus.pre_synp_avail, 1);
        tick();
        check_eq("t2_pulse_width", bus.pre_synp_avail, 0);
        for (int i = 1; i < TS; i++) push_vec($urandom);
        wait_done("t2_done", 600);
        tick();

        // frame 3: sink stalls for 5 cycles on the first output
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < TS; i++) push_vec($urandom);
            end
            begin
                start_frame();
                n = 0;
                while (!bus.out_valid && n < 200) begin
                    tick();
                    n++;
                end
                check_true("t3_out_valid_seen", bus.out_valid);
                sp = bus.out_spk;
                st = bus.out_step;
                pc0 = pulse_cnt;
                repeat (5) begin
                    tick();
                    check_eq("t3_hold_valid", bus.out_valid, 1);
                    check_eq("t3_hold_spk", bus.out_spk, sp);
                    check_eq("t3_hold_step", bus.out_step, st);
                end
                check_eq("t3_no_issue_stalled", pulse_cnt, pc0);
                bus.out_ready = 1'b1;
                wait_done("t3_done", 600);
            end
        join
        tick();

        // frame 4: full FIFO, pop frees exactly one slot
        for (int i = 0; i < FD; i++) push_vec($urandom);
        tick();
        check_eq("t4_full_in_ready", bus.in_ready, 0);
        start_frame();
        push_vec(32'h5555_AAAA);
        check_eq("t4_full_again", bus.in_ready, 0);
        push_vec(32'h1234_5678);
        wait_done("t4_done", 600);
        tick();

        // randomized frames against the queue model
        hold_min = 1;
        hold_max = 5;
        for (int f = 0; f < 4; f++) begin
            rnd_run = 1;
            fork
                begin
                    for (int k = 0; k < TS; k++) begin
                        repeat ($urandom_range(3, 0)) tick();
                        push_vec($urandom);
                    end
                end
                begin
                    while (rnd_run) begin
                        bus.out_ready = $urandom_range(1, 0);
                        tick();
                    end
                    bus.out_ready = 1'b1;
                end
                begin
                    start_frame();
                    wait_done("rand_done", 3000);
                    rnd_run = 0;
                end
            join
            tick();
        end
        check_eq("rand_issue_drained", exp_issue_q.size(), 0);
        check_eq("rand_out_drained", exp_out_q.size(), 0);
        check_eq("rand_err_clear", bus.err_timeout, 0);

        // frame 6: layer never drops avail
        hold_min = 3;
        hold_max = 3;
        layer_stuck = 1;
        push_vec(32'h0F0F_0F0F);
        start_frame();
        n = 0;
        while (!bus.pre_synp_avail && n < 50) begin
            tick();
            n++;
        end
        check_true("t6_pulse_seen", bus.pre_synp_avail);
        c0 = cyc;
        d0 = done_cnt;
        n = 0;
        while (!bus.err_timeout && n < 200) begin
            tick();
            n++;
        end
        check_true("t6_err_set", bus.err_timeout);
        check_true("t6_timeout_cycles", (cyc - c0 >= ACK) && (cyc - c0 <= ACK + 1));
        tick();
        tick();
        check_true("t6_done_pulse", done_cnt == d0 + 1);
        check_eq("t6_idle", bus.busy, 0);
        layer_stuck = 0;
        exp_out_q.delete();
        repeat (3) tick();
        check_eq("t6_err_sticky", bus.err_timeout, 1);

        // frame 7: reset in WAIT_DONE of step 2, then a clean frame
        fork
            begin
                for (int i = 0; i < TS; i++) push_vec($urandom);
            end
            begin
                pc0 = pulse_cnt;
                start_frame();
                n = 0;
                while (pulse_cnt < pc0 + 3 && n < 400) begin
                    tick();
                    n++;
                end
                check_true("t7_reach_step2", pulse_cnt == pc0 + 3);
            end
        join
        tick();
        tick();
        check_eq("t7_in_wait_done", bus.layer_avail, 0);
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        check_eq("t7_rst_busy", bus.busy, 0);
        check_eq("t7_rst_pulse", bus.pre_synp_avail, 0);
        check_eq("t7_rst_train", bus.pre_synpt_spk_train, 0);
        check_eq("t7_rst_out_valid", bus.out_valid, 0);
        check_eq("t7_rst_out_spk", bus.out_spk, 0);
        check_eq("t7_rst_out_step", bus.out_step, 0);
        check_eq("t7_rst_err", bus.err_timeout, 0);
        check_eq("t7_rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        exp_issue_q.delete();
        exp_out_q.delete();
        tick();
        tick();
        check_eq("t7_no_done", done_cnt, d0);
        pc0 = pulse_cnt;
        start_frame();
        repeat (8) tick();
        check_eq("t7_fifo_flushed", pulse_cnt, pc0);
        for (int i = 0; i < TS; i++) push_vec($urandom);
        wait_done("t7_clean_done", 600);
        check_eq("t7_clean_pulses", pulse_cnt, pc0 + TS);
        check_eq("t7_out_drained", exp_out_q.size(), 0);
        check_eq("t7_err_clear", bus.err_timeout, 0);
        tick();
        check_eq("t7_idle", bus.busy, 0);

        finished = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        if (!finished) begin
            failures++;
            $display("FAIL watchdog actual=running expected=finished at cycle %0d", cyc);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

endmodule
